// File: rtl/prbs_gen_chk.sv
// Fibonacci LFSR pattern generator plus a self-synchronising PRBS checker.
// The checker hunts for LOCK_CNT correctly predicted bits, then free-runs and counts mismatches.
module prbs_gen_chk #(
    parameter int unsigned      WIDTH      = 7,
    parameter logic [WIDTH-1:0] TAPS       = 7'h03,
    parameter logic [WIDTH-1:0] SEED       = 7'h7F,
    parameter int unsigned      LOCK_CNT   = 8,
    parameter int unsigned      UNLOCK_ERR = 4,
    parameter int unsigned      ERR_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rand_state,
    output logic             gen_bit,
    input  logic             chk_valid,
    input  logic             chk_bit,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] LOCK_TARGET   = 8'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TARGET = 4'(UNLOCK_ERR);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] chk_reg, chk_reg_nxt;
    logic [7:0]       good_cnt, good_cnt_nxt;
    logic [3:0]       bad_cnt, bad_cnt_nxt;
    logic             err_pulse_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic             pred;

    // Generator: a zero seed would lock the LFSR up, so it falls back to SEED.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rand_state <= SEED;
        end else if (load) begin
            rand_state <= (seed_in == '0) ? SEED : seed_in;
        end else if (en) begin
            rand_state <= {^(rand_state & TAPS), rand_state[WIDTH-1:1]};
        end
    end

    assign gen_bit = rand_state[0];

    assign pred   = ^(chk_reg & TAPS);
    assign locked = (state == LOCK);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= HUNT;
            chk_reg   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            chk_reg   <= chk_reg_nxt;
            good_cnt  <= good_cnt_nxt;
            bad_cnt   <= bad_cnt_nxt;
            err_pulse <= err_pulse_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        chk_reg_nxt   = chk_reg;
        good_cnt_nxt  = good_cnt;
        bad_cnt_nxt   = bad_cnt;
        err_pulse_nxt = 1'b0;
        err_cnt_nxt   = err_cnt;
        if (chk_valid) begin
            case (state)
                HUNT: begin
                    chk_reg_nxt = {chk_bit, chk_reg[WIDTH-1:1]};
                    if ((chk_bit == pred) && (chk_reg != '0)) begin
                        good_cnt_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_TARGET) begin
                            state_nxt   = LOCK;
                            bad_cnt_nxt = '0;
                        end
                    end else begin
                        good_cnt_nxt = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: the local copy keeps running on its own prediction.
                    chk_reg_nxt = {pred, chk_reg[WIDTH-1:1]};
                    if (chk_bit == pred) begin
                        bad_cnt_nxt = '0;
                    end else begin
                        err_pulse_nxt = 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt_nxt = err_cnt + ERR_W'(1);
                        end
                        bad_cnt_nxt = bad_cnt + 4'd1;
                        if (bad_cnt + 4'd1 == UNLOCK_TARGET) begin
                            state_nxt    = HUNT;
                            good_cnt_nxt = '0;
                            bad_cnt_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (clr_err) begin
            err_cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: a 4-bit instance for the fixed generator sequence and counter
// saturation, and a default-parameter instance checked against a bit-stream reference model.
module tb_prbs_gen_chk;

    localparam int W = 7;
    localparam logic [6:0] D_TAPS = 7'h03;
    localparam logic [6:0] D_SEED = 7'h7F;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    // 4-bit instance signals
    logic       g_en = 0, g_load = 0, g_cv = 0, g_cb = 0, g_clr_err = 0;
    logic [3:0] g_seed = '0;
    logic [3:0] g_rand;
    logic       g_bit, g_locked, g_err_pulse;
    logic [2:0] g_err_cnt;

    // default instance signals
    logic        d_en = 0, d_load = 0, d_cv = 0, d_cb = 0, d_clr_err = 0;
    logic [6:0]  d_seed = '0;
    logic [6:0]  d_rand;
    logic        d_bit, d_locked, d_err_pulse;
    logic [15:0] d_err_cnt;

    prbs_gen_chk #(.WIDTH(4), .TAPS(4'h3), .SEED(4'hF), .LOCK_CNT(8), .UNLOCK_ERR(4), .ERR_W(3)) u_g4 (
        .clk(clk), .clr(clr), .en(g_en), .load(g_load), .seed_in(g_seed),
        .rand_state(g_rand), .gen_bit(g_bit), .chk_valid(g_cv), .chk_bit(g_cb),
        .clr_err(g_clr_err), .locked(g_locked), .err_pulse(g_err_pulse), .err_cnt(g_err_cnt)
    );

    prbs_gen_chk u_dut (
        .clk(clk), .clr(clr), .en(d_en), .load(d_load), .seed_in(d_seed),
        .rand_state(d_rand), .gen_bit(d_bit), .chk_valid(d_cv), .chk_bit(d_cb),
        .clr_err(d_clr_err), .locked(d_locked), .err_pulse(d_err_pulse), .err_cnt(d_err_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model. fut holds the generator's next W stream bits (oldest first);
    // hist holds the checker's view of the last W stream bits (oldest first).
    bit fut[$];
    bit hist[$];
    bit m_locked, m_pulse;
    int m_good, m_bad, m_err;

    function automatic void m_reset();
        fut.delete();
        hist.delete();
        for (int i = 0; i < W; i++) begin
            fut.push_back(D_SEED[i]);
            hist.push_back(1'b0);
        end
        m_locked = 0; m_pulse = 0; m_good = 0; m_bad = 0; m_err = 0;
    endfunction

    // Stream recurrence: b[n+W] = XOR of b[n+i] over every tap i.
    function automatic bit recur_fut();
        bit r = 1'b0;
        for (int i = 0; i < W; i++) if (D_TAPS[i]) r ^= fut[i];
        return r;
    endfunction

    function automatic bit recur_hist();
        bit r = 1'b0;
        for (int i = 0; i < W; i++) if (D_TAPS[i]) r ^= hist[i];
        return r;
    endfunction

    function automatic logic [6:0] m_rand();
        logic [6:0] v;
        for (int i = 0; i < W; i++) v[i] = fut[i];
        return v;
    endfunction

    function automatic void gen_model(input bit en, input bit ld, input logic [6:0] sd);
        logic [6:0] v;
        bit nb;
        if (ld) begin
            v = (sd == 7'd0) ? D_SEED : sd;
            fut.delete();
            for (int i = 0; i < W; i++) fut.push_back(v[i]);
        end else if (en) begin
            nb = recur_fut();
            void'(fut.pop_front());
            fut.push_back(nb);
        end
    endfunction

    function automatic void chk_model(input bit cv, input bit cb, input bit ce);
        bit p, nz;
        m_pulse = 0;
        if (cv) begin
            p  = recur_hist();
            nz = 0;
            for (int i = 0; i < W; i++) nz |= hist[i];
            void'(hist.pop_front());
            if (!m_locked) begin
                hist.push_back(cb);
                if (cb == p && nz) begin
                    m_good++;
                    if (m_good == 8) begin m_locked = 1; m_bad = 0; end
                end else begin
                    m_good = 0;
                end
            end else begin
                hist.push_back(p);
                if (cb == p) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_bad++;
                    if (m_bad == 4) begin m_locked = 0; m_good = 0; m_bad = 0; end
                end
            end
        end
        if (ce) m_err = 0;
    endfunction

    // One clock of the default instance, checked against the model afterwards.
    task automatic step_d(input bit en, input bit ld, input logic [6:0] sd,
                          input bit cv, input bit cb, input bit ce);
        d_en = en; d_load = ld; d_seed = sd; d_cv = cv; d_cb = cb; d_clr_err = ce;
        tick();
        gen_model(en, ld, sd);
        chk_model(cv, cb, ce);
        check("rand", 32'(d_rand), 32'(m_rand()));
        check("gen_bit", 32'(d_bit), 32'(fut[0]));
        check("locked", 32'(d_locked), 32'(m_locked));
        check("err_pulse", 32'(d_err_pulse), 32'(m_pulse));
        check("err_cnt", 32'(d_err_cnt), 32'(m_err));
    endtask

    task automatic loop_d(input bit inv, input bit ce);
        step_d(1'b1, 1'b0, 7'd0, 1'b1, d_bit ^ inv, ce);
    endtask

    typedef struct {
        bit         en;
        bit         load;
        logic [3:0] seed;
        logic [3:0] exp_rand;
        bit         exp_bit;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input bit e, input bit l, input logic [3:0] s,
                                    input logic [3:0] r, input bit b);
        vec_t v;
        v.en = e; v.load = l; v.seed = s; v.exp_rand = r; v.exp_bit = b;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ever_locked;
        bit r_en, r_ld, r_cv, r_inv, r_ce;
        logic [6:0] r_sd;

        // full period of x^4+x^3+1 from F, hold, then load cases
        add_vec(1, 0, 4'h0, 4'h7, 1); add_vec(1, 0, 4'h0, 4'h3, 1); add_vec(1, 0, 4'h0, 4'h1, 1);
        add_vec(1, 0, 4'h0, 4'h8, 0); add_vec(1, 0, 4'h0, 4'h4, 0); add_vec(1, 0, 4'h0, 4'h2, 0);
        add_vec(1, 0, 4'h0, 4'h9, 1); add_vec(1, 0, 4'h0, 4'hC, 0); add_vec(1, 0, 4'h0, 4'h6, 0);
        add_vec(1, 0, 4'h0, 4'hB, 1); add_vec(1, 0, 4'h0, 4'h5, 1); add_vec(1, 0, 4'h0, 4'hA, 0);
        add_vec(1, 0, 4'h0, 4'hD, 1); add_vec(1, 0, 4'h0, 4'hE, 0); add_vec(1, 0, 4'h0, 4'hF, 1);
        add_vec(0, 0, 4'h0, 4'hF, 1); add_vec(0, 0, 4'h0, 4'hF, 1); add_vec(0, 0, 4'h0, 4'hF, 1);
        add_vec(0, 1, 4'h9, 4'h9, 1); add_vec(1, 0, 4'h0, 4'hC, 0);
        add_vec(0, 1, 4'h0, 4'hF, 1); add_vec(1, 1, 4'h5, 4'h5, 1);
        add_vec(1, 0, 4'h0, 4'hA, 0); add_vec(0, 0, 4'h0, 4'hA, 0);

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_g_rand", 32'(g_rand), 32'hF);
        check("rst_d_rand", 32'(d_rand), 32'h7F);
        check("rst_d_bit", 32'(d_bit), 32'h1);
        check("rst_locked", 32'(d_locked), 32'h0);
        check("rst_err_pulse", 32'(d_err_pulse), 32'h0);
        check("rst_err_cnt", 32'(d_err_cnt), 32'h0);
        clr = 1'b0;
        m_reset();

        foreach (vecs[i]) begin
            g_en = vecs[i].en; g_load = vecs[i].load; g_seed = vecs[i].seed;
            tick();
            check($sformatf("vec%0d_rand", i), 32'(g_rand), 32'(vecs[i].exp_rand));
            check($sformatf("vec%0d_bit", i), 32'(g_bit), 32'(vecs[i].exp_bit));
        end

        // 4-bit loopback lock, then isolated errors to saturate the 3-bit counter
        g_load = 0; g_en = 1; g_cv = 1;
        cyc = 0;
        while (!g_locked && cyc < 40) begin
            g_cb = g_bit;
            tick();
            cyc++;
        end
        check("g4_lock", 32'(g_locked), 32'h1);
        for (int k = 0; k < 10; k++) begin
            g_cb = ~g_bit;
            tick();
            g_cb = g_bit;
            tick();
        end
        check("g4_err_sat", 32'(g_err_cnt), 32'h7);
        check("g4_still_locked", 32'(g_locked), 32'h1);
        g_cb = g_bit; g_clr_err = 1;
        tick();
        g_clr_err = 0;
        check("g4_clr_err", 32'(g_err_cnt), 32'h0);
        g_en = 0; g_cv = 0;

        // default loopback lock within WIDTH+LOCK_CNT+1 cycles
        cyc = 0;
        while (!d_locked && cyc < 16) begin
            loop_d(0, 0);
            cyc++;
        end
        check("lock_within_16", 32'(d_locked), 32'h1);
        for (int k = 0; k < 1000; k++) loop_d(0, 0);
        check("clean_err_cnt", 32'(d_err_cnt), 32'h0);

        // single error, then clear coincident with a second error
        loop_d(1, 0);
        check("single_pulse", 32'(d_err_pulse), 32'h1);
        check("single_cnt", 32'(d_err_cnt), 32'h1);
        check("single_locked", 32'(d_locked), 32'h1);
        loop_d(0, 0);
        check("pulse_one_cycle", 32'(d_err_pulse), 32'h0);
        loop_d(1, 1);
        check("clr_wins", 32'(d_err_cnt), 32'h0);
        repeat (3) loop_d(0, 0);

        // burst of 4 drops lock on the 4th
        for (int k = 0; k < 3; k++) loop_d(1, 0);
        check("burst3_locked", 32'(d_locked), 32'h1);
        loop_d(1, 0);
        check("burst4_unlocked", 32'(d_locked), 32'h0);
        check("burst_cnt", 32'(d_err_cnt), 32'h4);
        cyc = 0;
        while (!d_locked && cyc < 16) begin
            loop_d(0, 0);
            cyc++;
        end
        check("relock", 32'(d_locked), 32'h1);

        // asynchronous clear mid-LOCK with a pulse outstanding
        loop_d(1, 0);
        check("pre_clr_pulse", 32'(d_err_pulse), 32'h1);
        #2;
        clr = 1'b1;
        #1;
        check("async_rand", 32'(d_rand), 32'h7F);
        check("async_bit", 32'(d_bit), 32'h1);
        check("async_locked", 32'(d_locked), 32'h0);
        check("async_pulse", 32'(d_err_pulse), 32'h0);
        check("async_err_cnt", 32'(d_err_cnt), 32'h0);
        check("async_g_rand", 32'(g_rand), 32'hF);
        tick();
        clr = 1'b0;
        m_reset();

        // constant zero input never locks
        ever_locked = 0;
        for (int k = 0; k < 500; k++) begin
            step_d(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
            ever_locked |= d_locked;
        end
        check("zero_never_locks", 32'(ever_locked), 32'h0);

        // randomized mix against the model
        for (int k = 0; k < 1500; k++) begin
            r_en  = ($urandom_range(0, 7) != 0);
            r_ld  = ($urandom_range(0, 31) == 0);
            r_sd  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            r_cv  = ($urandom_range(0, 3) != 0);
            r_inv = ($urandom_range(0, 24) == 0);
            r_ce  = ($urandom_range(0, 63) == 0);
            step_d(r_en, r_ld, r_sd, r_cv, d_bit ^ r_inv, r_ce);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
